// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared types and constants for the instruction-memory loader
package im_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    localparam int LANE_W = 2;
    localparam int WORD_W = BYTE_W * LANES;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FINISH = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/im_loader_if.sv
// rtl/im_loader_if.sv - byte-stream input and instruction-memory write port bundle
interface im_loader_if #(
    parameter int ADDR_W = 10
);
    logic                              s_valid;
    logic                              s_ready;
    logic [im_loader_pkg::BYTE_W-1:0]  s_data;
    logic                              s_last;
    logic                              im_we;
    logic [ADDR_W-1:0]                 im_addr;
    logic [im_loader_pkg::WORD_W-1:0]  im_wdata;

    // Loader side: consumes the stream, drives the memory write port.
    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, im_we, im_addr, im_wdata
    );

    // Host side: produces the stream, observes the memory write port.
    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/im_word_packer.sv
// rtl/im_word_packer.sv - big-endian byte-to-word packer with left-aligned padding
module im_word_packer
    import im_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              last_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_ready_o
);

    // Only the three previously accepted bytes are needed; the fourth is data_i itself.
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [23:0]       pack_q, pack_d;

    // Form the left-aligned word including the incoming byte, and the next lane/pack state.
    always_comb begin
        word_ready_o = accept_i && ((lane_q == LANE_W'(LANES - 1)) || last_i);
        word_o       = '0;
        case (lane_q)
            2'd0:    word_o = {data_i, 24'h000000};
            2'd1:    word_o = {pack_q[7:0], data_i, 16'h0000};
            2'd2:    word_o = {pack_q[15:0], data_i, 8'h00};
            default: word_o = {pack_q[23:0], data_i};
        endcase
        lane_d = lane_q;
        pack_d = pack_q;
        if (clear_i) begin
            lane_d = '0;
            pack_d = '0;
        end else if (accept_i) begin
            pack_d = {pack_q[15:0], data_i};
            lane_d = word_ready_o ? '0 : lane_q + LANE_W'(1);
        end
    end

    // Lane and shift register; held across stream gaps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q <= '0;
            pack_q <= '0;
        end else begin
            lane_q <= lane_d;
            pack_q <= pack_d;
        end
    end

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - loads a byte stream into instruction memory and holds the CPU in reset meanwhile
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    im_loader_if.slave        bus,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W:0]   words,
    output logic              overflow,
    output logic [WORD_W-1:0] xsum
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [WORD_W-1:0]   xsum_q, xsum_d;
    logic                ovf_q, ovf_d;

    logic                accept;
    logic                clear;
    logic                word_ready;
    logic [WORD_W-1:0]   word;

    assign accept = bus.s_valid && (state_q == ST_LOAD);
    assign clear  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    im_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear),
        .accept_i     (accept),
        .data_i       (bus.s_data),
        .last_i       (bus.s_last),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    // Next state, write registers and counters; a write past DEPTH only raises overflow.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        words_d = words_q;
        xsum_d  = xsum_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD;
            ST_LOAD:   if (accept && bus.s_last) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_DONE;
            ST_DONE:   if (start) state_d = ST_LOAD;
            default:   state_d = ST_IDLE;
        endcase
        if (clear) begin
            words_d = '0;
            xsum_d  = '0;
            ovf_d   = 1'b0;
        end
        if (word_ready) begin
            if (words_q == DEPTH_W) begin
                ovf_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = words_q[ADDR_W-1:0];
                wdata_d = word;
                words_d = words_q + (ADDR_W + 1)'(1);
                xsum_d  = xsum_q ^ word;
            end
        end
    end

    // State and datapath registers; reset abandons any partial load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            words_q <= '0;
            xsum_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            words_q <= words_d;
            xsum_q  <= xsum_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.s_ready  = (state_q == ST_LOAD);
    assign bus.im_we    = we_q;
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = wdata_q;
    assign done         = (state_q == ST_DONE);
    assign cpu_hold     = (state_q != ST_DONE);
    assign words        = words_q;
    assign overflow     = ovf_q;
    assign xsum         = xsum_q;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - directed scoreboard bench for im_loader
module tb_im_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_m, start_s;
    logic        hold_m, done_m, ovf_m, hold_s, done_s, ovf_s;
    logic [10:0] words_m;
    logic [2:0]  words_s;
    logic [31:0] xsum_m, xsum_s;

    im_loader_if #(.ADDR_W(10)) bus_m ();
    im_loader_if #(.ADDR_W(2))  bus_s ();

    im_loader #(.ADDR_W(10), .DEPTH(1024)) u_dut (
        .clk(clk), .reset(reset), .start(start_m), .bus(bus_m),
        .cpu_hold(hold_m), .done(done_m), .words(words_m), .overflow(ovf_m), .xsum(xsum_m)
    );

    im_loader #(.ADDR_W(2), .DEPTH(4)) u_small (
        .clk(clk), .reset(reset), .start(start_s), .bus(bus_s),
        .cpu_hold(hold_s), .done(done_s), .words(words_s), .overflow(ovf_s), .xsum(xsum_s)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_m[$];
    wr_t         exp_s[$];
    wr_t         e_m, e_s;
    int          tests = 0;
    int          fails = 0;
    logic        prev_m = 1'b0;
    logic        prev_s = 1'b0;
    int          exp_words;
    logic [31:0] exp_xsum;
    logic        exp_ovf;
    logic        exp_last_we;
    logic [7:0]  prog8[$];
    logic [7:0]  prog3[$];
    logic [7:0]  prog4[$];
    logic [7:0]  prog20[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input bit sel);
        return sel ? bus_s.s_ready : bus_m.s_ready;
    endfunction
    function automatic logic get_we(input bit sel);
        return sel ? bus_s.im_we : bus_m.im_we;
    endfunction
    function automatic logic get_done(input bit sel);
        return sel ? done_s : done_m;
    endfunction
    function automatic logic get_hold(input bit sel);
        return sel ? hold_s : hold_m;
    endfunction
    function automatic logic get_ovf(input bit sel);
        return sel ? ovf_s : ovf_m;
    endfunction
    function automatic logic [10:0] get_words(input bit sel);
        return sel ? {8'b0, words_s} : words_m;
    endfunction
    function automatic logic [31:0] get_xsum(input bit sel);
        return sel ? xsum_s : xsum_m;
    endfunction
    function automatic int qsize(input bit sel);
        return sel ? exp_s.size() : exp_m.size();
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] d, input logic l);
        if (sel) begin
            bus_s.s_valid = v; bus_s.s_data = d; bus_s.s_last = l;
        end else begin
            bus_m.s_valid = v; bus_m.s_data = d; bus_m.s_last = l;
        end
    endtask

    // Write-port monitor: every im_we pulse is popped against the scoreboard.
    always @(negedge clk) begin
        if (bus_m.im_we === 1'b1) begin
            check("m_we_consecutive", prev_m, 0);
            check("m_we_expected", exp_m.size() > 0, 1);
            if (exp_m.size() > 0) begin
                e_m = exp_m.pop_front();
                check("m_im_addr", bus_m.im_addr, e_m.addr);
                check("m_im_wdata", bus_m.im_wdata, e_m.data);
            end
        end
        if (bus_s.im_we === 1'b1) begin
            check("s_we_consecutive", prev_s, 0);
            check("s_we_expected", exp_s.size() > 0, 1);
            if (exp_s.size() > 0) begin
                e_s = exp_s.pop_front();
                check("s_im_addr", bus_s.im_addr, e_s.addr);
                check("s_im_wdata", bus_s.im_wdata, e_s.data);
            end
        end
        prev_m = bus_m.im_we;
        prev_s = bus_s.im_we;
    end

    task automatic send_byte(input bit sel, input logic [7:0] d, input logic l);
        int n = 0;
        drive(sel, 1'b1, d, l);
        @(negedge clk);
        while (get_ready(sel) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(sel ? "s_ready_timeout" : "m_ready_timeout", n < 50, 1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_stream(input bit sel, input logic [7:0] b[$], input int gapmax,
                               input int depth, input bit with_last);
        int          lane = 0;
        int          cnt = 0;
        logic [31:0] w = '0;
        exp_xsum    = '0;
        exp_ovf     = 1'b0;
        exp_last_we = 1'b0;
        for (int i = 0; i < b.size(); i++) begin
            bit l = with_last && (i == b.size() - 1);
            if (i > 0 && gapmax > 0) begin
                int g = $urandom_range(gapmax, 0);
                repeat (g) @(posedge clk);
                if (g > 0) #1;
            end
            w[31 - 8*lane -: 8] = b[i];
            if (lane == 3 || l) begin
                if (l) exp_last_we = (cnt < depth);
                if (cnt < depth) begin
                    if (sel) exp_s.push_back('{addr: cnt, data: w});
                    else     exp_m.push_back('{addr: cnt, data: w});
                    exp_xsum ^= w;
                    cnt++;
                end else begin
                    exp_ovf = 1'b1;
                end
                w    = '0;
                lane = 0;
            end else begin
                lane++;
            end
            send_byte(sel, b[i], l);
        end
        exp_words = cnt;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_s = 1'b1; else start_m = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        start_m = 1'b0;
    endtask

    task automatic finish_check(input bit sel);
        @(negedge clk);
        check("finish_im_we", get_we(sel), exp_last_we);
        check("finish_done_low", get_done(sel), 0);
        @(negedge clk);
        check("done_rise", get_done(sel), 1);
        check("cpu_hold_fall", get_hold(sel), 0);
        check("im_we_after_done", get_we(sel), 0);
        check("words", get_words(sel), exp_words);
        check("xsum", get_xsum(sel), exp_xsum);
        check("overflow", get_ovf(sel), exp_ovf);
        check("scoreboard_empty", qsize(sel), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        prog8 = '{8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        prog3 = '{8'hAA, 8'hBB, 8'hCC};
        prog4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 20; i++) prog20.push_back(8'(i + 1));
        reset   = 1'b0;
        start_m = 1'b0;
        start_s = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", bus_m.s_ready, 0);
        check("rst_im_we", bus_m.im_we, 0);
        check("rst_im_addr", bus_m.im_addr, 0);
        check("rst_im_wdata", bus_m.im_wdata, 0);
        check("rst_cpu_hold", hold_m, 1);
        check("rst_done", done_m, 0);
        check("rst_words", words_m, 0);
        check("rst_overflow", ovf_m, 0);
        check("rst_xsum", xsum_m, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_s_ready", bus_m.s_ready, 0);

        // Two full words from IDLE.
        pulse_start(0);
        send_stream(0, prog8, 0, 1024, 1);
        finish_check(0);
        check("t1_words", words_m, 2);
        check("t1_xsum", xsum_m, 32'h24010009);

        // Restart from DONE: hold and counters return on the start edge.
        pulse_start(0);
        check("restart_cpu_hold", hold_m, 1);
        check("restart_done", done_m, 0);
        check("restart_words", words_m, 0);
        check("restart_xsum", xsum_m, 0);
        send_stream(0, prog4, 0, 1024, 1);
        finish_check(0);
        check("t6_words", words_m, 1);
        check("t6_xsum", xsum_m, 32'h11223344);

        // Partial final word is zero padded.
        pulse_start(0);
        send_stream(0, prog3, 0, 1024, 1);
        finish_check(0);
        check("t2_words", words_m, 1);
        check("t2_overflow", ovf_m, 0);
        check("t2_xsum", xsum_m, 32'hAABBCC00);

        // Random valid gaps.
        pulse_start(0);
        send_stream(0, prog8, 5, 1024, 1);
        finish_check(0);
        check("t3_xsum", xsum_m, 32'h24010009);

        // Reset in the middle of a load.
        pulse_start(0);
        send_stream(0, prog8[0:5], 0, 1024, 0);
        reset = 1'b0;
        #1;
        check("midrst_s_ready", bus_m.s_ready, 0);
        check("midrst_cpu_hold", hold_m, 1);
        check("midrst_im_we", bus_m.im_we, 0);
        check("midrst_words", words_m, 0);
        check("midrst_queue", exp_m.size(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        pulse_start(0);
        send_stream(0, prog8, 0, 1024, 1);
        finish_check(0);
        check("t4_xsum", xsum_m, 32'h24010009);

        // DEPTH=4 instance overrun by a 20-byte stream.
        pulse_start(1);
        send_stream(1, prog20, 0, 4, 1);
        finish_check(1);
        check("t5_words", words_s, 3'd4);
        check("t5_overflow", ovf_s, 1);
        check("t5_xsum", xsum_s, 32'h01020304 ^ 32'h05060708 ^ 32'h090A0B0C ^ 32'h0D0E0F10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/im_loader.md
# im_loader

Instruction-memory loader: the write side of the instruction store that the IFU reads from. It accepts a byte stream from a host or test channel, packs the bytes big-endian into 32-bit words, and writes them into consecutive instruction-memory word slots starting at word 0 (the IFU reset PC). It holds the CPU in reset until the whole program is written.

## Interface
Parameters:
- `ADDR_W`, default 10: instruction-memory word-address width.
- `DEPTH`, default 1024: number of writable words; must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load; acted on only in IDLE or DONE.
- `s_valid`  in  1  byte-stream valid.
- `s_ready`  out  1  byte-stream ready.
- `s_data`  in  8  stream byte; the first byte of each word is the MSB.
- `s_last`  in  1  marks the final byte of the program.
- `im_we`  out  1  instruction-memory write enable, one-cycle pulse per word.
- `im_addr`  out  ADDR_W  word address of the current write.
- `im_wdata`  out  32  word being written.
- `cpu_hold`  out  1  holds the CPU/IFU in reset while high.
- `done`  out  1  load complete.
- `words`  out  ADDR_W+1  number of words actually written.
- `overflow`  out  1  sticky; set when the stream exceeded `DEPTH` words.
- `xsum`  out  32  XOR of all words actually written.

## Operation
States: IDLE, LOAD, FINISH, DONE.
- IDLE: `s_ready`=0. `start` moves the FSM to LOAD.
- LOAD: `s_ready`=1. A byte is accepted when `s_valid && s_ready`.
  - Each accepted byte shifts in: pack = {pack[23:0], s_data}. The lane counter runs 0..3.
  - Lane 3 accepted, or `s_last` accepted: register a write.
    - Write data is the pack left-aligned, with unfilled low bytes zero. Example: 3 bytes give {b0,b1,b2,8'h00}.
    - Write address is `words[ADDR_W-1:0]`.
    - After the write, the lane resets to 0, `words` increments and `xsum` ^= data.
  - If `words == DEPTH` when a write is due: suppress `im_we`, set `overflow`, and leave `words`/`xsum` unchanged. Bytes are still consumed until `s_last`.
  - Accepting `s_last` moves the FSM to FINISH.
- FINISH: lasts exactly one cycle. `s_ready`=0. The final `im_we` pulse (if not suppressed) is visible during this cycle. Next state is DONE.
- DONE: `done`=1, `cpu_hold`=0, `s_ready`=0. `start` returns the FSM to LOAD and, on that same edge:
  - clears `words`, `xsum`, `overflow`, lane and `done`;
  - reasserts `cpu_hold`.
- `start` in LOAD or FINISH is ignored.
- `cpu_hold` = (state != DONE).
- An empty stream is impossible: `s_last` always accompanies a byte.

## Timing
- Reset values: state=IDLE, `s_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_hold`=1, `done`=0, `words`=0, `overflow`=0, `xsum`=0.
- Reset asserted mid-load: the FSM returns to IDLE immediately and any partial word is discarded. Words already written stay in memory; `words`/`xsum` clear.
- Write latency: `im_we` is high in the cycle after the edge that accepted the completing byte.
- `im_addr` and `im_wdata` are registered and stable while `im_we` is high.
- Back-to-back bytes at full rate produce at most one write every 4 cycles; `im_we` never stays high for 2 consecutive cycles.
- Gaps in `s_valid` are allowed anywhere. Lane state is held across gaps.
- `done` rises and `cpu_hold` falls exactly one cycle after the last `im_we` pulse. The CPU therefore never fetches from a slot that is mid-write.
- `words` saturates at `DEPTH`. Its width is ADDR_W+1 so it can hold `DEPTH` = 2^ADDR_W.

## Structure
- Shared package `im_loader_pkg`: state enum (IDLE/LOAD/FINISH/DONE) and byte-lane width constants.
- Sub-module `im_word_packer`:
  - holds the shift register and lane counter;
  - produces a left-aligned padded word and a `word_ready` strobe.
- The FSM, counters, overflow logic and write registers live in the top level.

## Test plan
- Bytes 24 01 00 05 00 00 00 0C, with `s_last` on the final byte:
  - writes addr 0 = 0x24010005 and addr 1 = 0x0000000C;
  - `words`=2, `xsum`=0x24010009;
  - `done` rises one cycle after the 2nd `im_we`.
- Bytes AA BB CC, with `s_last` on CC:
  - single write addr 0 = 0xAABBCC00;
  - `words`=1, `overflow`=0.
- Same 8 bytes as the first test with random `s_valid` gaps of 0–5 cycles:
  - identical writes and `xsum`;
  - no extra `im_we`;
  - `im_we` never high for 2 consecutive cycles.
- `DEPTH`=4, 20 bytes:
  - exactly 4 writes at addrs 0–3;
  - `overflow`=1, `words`=4, all bytes consumed;
  - DONE reached.
- Reset low after 6 bytes accepted:
  - immediate `s_ready`=0, `cpu_hold`=1, no `im_we`;
  - after release, `start` plus the 8-byte stream rewrites from addr 0 correctly.
- In DONE, pulse `start` and stream 4 bytes 11 22 33 44 with last:
  - `cpu_hold` reasserts on that edge;
  - `words` clears, then ends at 1; `xsum`=0x11223344.
